// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared widths, FSM state codes and owner codes for the data memory arbiter
package dmem_arb_pkg;

    localparam int REG_WIDTH  = 12;
    localparam int ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RDATA = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner select; ARB_ROUND_ROBIN_EN selects round robin, else fixed CPU priority
module arb_pick
    import dmem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   host_req,
    input  owner_e last_owner,
    output owner_e winner
);

    always_comb begin
        winner = last_owner;
        if (cpu_req && host_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            // On a tie, hand the memory to whoever was not served last
            winner = (last_owner == OWN_CPU) ? OWN_HOST : OWN_CPU;
`else
            winner = OWN_CPU;
`endif
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end else if (host_req) begin
            winner = OWN_HOST;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - serialises CPU and host accesses to the single-port data memory (ARB_ROUND_ROBIN_EN in arb_pick)
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int reg_width  = REG_WIDTH,
    parameter int addr_width = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [addr_width-1:0] cpu_addr,
    input  logic [reg_width-1:0]  cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [reg_width-1:0]  cpu_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [addr_width-1:0] host_addr,
    input  logic [reg_width-1:0]  host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [reg_width-1:0]  host_rdata,
    output logic [addr_width-1:0] mem_address,
    output logic [reg_width-1:0]  mem_data,
    output logic                  mem_wren,
    input  logic [reg_width-1:0]  mem_q,
    output logic                  busy,
    output logic                  owner
);

    state_e                  state_q;
    owner_e                  owner_q;
    owner_e                  winner;
    logic                    cpu_gnt_q, host_gnt_q;
    logic                    cpu_rvalid_q, host_rvalid_q;
    logic [reg_width-1:0]    cpu_rdata_q, host_rdata_q;
    logic [addr_width-1:0]   mem_address_q;
    logic [reg_width-1:0]    mem_data_q;
    logic                    mem_wren_q;
    logic                    sel_we;
    logic [addr_width-1:0]   sel_addr;
    logic [reg_width-1:0]    sel_wdata;

    arb_pick u_pick (
        .cpu_req    (cpu_req),
        .host_req   (host_req),
        .last_owner (owner_q),
        .winner     (winner)
    );

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (winner == OWN_HOST) begin
            sel_we    = host_we;
            sel_addr  = host_addr;
            sel_wdata = host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_HOST;
            cpu_gnt_q     <= 1'b0;
            host_gnt_q    <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            cpu_rdata_q   <= '0;
            host_rdata_q  <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
        end else begin
            // Handshake pulses and memory pins default low; only the issuing state raises them
            cpu_gnt_q     <= 1'b0;
            host_gnt_q    <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
            host_rvalid_q <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req || host_req) begin
                        owner_q       <= winner;
                        state_q       <= ST_GRANT;
                        mem_address_q <= sel_addr;
                        mem_data_q    <= sel_wdata;
                        mem_wren_q    <= sel_we;
                        cpu_gnt_q     <= (winner == OWN_CPU);
                        host_gnt_q    <= (winner == OWN_HOST);
                    end
                end
                ST_GRANT: begin
                    state_q <= mem_wren_q ? ST_IDLE : ST_RDATA;
                end
                ST_RDATA: begin
                    if (owner_q == OWN_CPU) begin
                        cpu_rdata_q  <= mem_q;
                        cpu_rvalid_q <= 1'b1;
                    end else begin
                        host_rdata_q  <= mem_q;
                        host_rvalid_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Reset must also block a write already sitting on the memory pins
    assign mem_wren    = mem_wren_q & reset;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign cpu_gnt     = cpu_gnt_q;
    assign host_gnt    = host_gnt_q;
    assign cpu_rvalid  = cpu_rvalid_q;
    assign host_rvalid = host_rvalid_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign host_rdata  = host_rdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign owner       = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a synchronous-read memory model
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, host_req, host_we;
    logic [11:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
    logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
    logic [11:0] cpu_rdata, host_rdata;
    logic [11:0] mem_address, mem_data, mem_q;
    logic        mem_wren, busy, owner;

    logic [11:0] mem [4096];
    logic [11:0] exp_mem [4096];
    logic [11:0] cpu_exp_q[$];
    logic [11:0] host_exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
        .busy(busy), .owner(owner)
    );

    always @(posedge clk) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (cpu_exp_q.size() == 0) check("cpu_rvalid_unexpected", 1, 0);
            else check("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
        end
        if (host_rvalid) begin
            if (host_exp_q.size() == 0) check("host_rvalid_unexpected", 1, 0);
            else check("host_rdata", host_rdata, host_exp_q.pop_front());
        end
        if (cpu_gnt || host_gnt) check("gnt_exclusive", cpu_gnt & host_gnt, 0);
    end

    task automatic access(input bit who, input bit we, input logic [11:0] addr, input logic [11:0] wdata);
        int lat;
        int cyc;
        bit got;
        if (who == 1'b0) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
        end
        if (!we) begin
            if (who == 1'b0) cpu_exp_q.push_back(exp_mem[addr]);
            else host_exp_q.push_back(exp_mem[addr]);
        end else begin
            exp_mem[addr] = wdata;
        end
        got = 1'b0;
        lat = 0;
        while (!got && lat < 10) begin
            tick();
            lat++;
            got = (who == 1'b0) ? cpu_gnt : host_gnt;
        end
        check("gnt_latency", lat, 1);
        if (got) begin
            check("mem_address", mem_address, addr);
            check("mem_wren", mem_wren, we);
            if (we) check("mem_data", mem_data, wdata);
            check("other_gnt", (who == 1'b0) ? host_gnt : cpu_gnt, 0);
        end
        cpu_req = 1'b0;
        host_req = 1'b0;
        cyc = 0;
        while (busy && cyc < 10) begin
            tick();
            cyc++;
        end
        check("busy_cycles", cyc, we ? 1 : 2);
        if (!we) check("rvalid_at_idle", (who == 1'b0) ? cpu_rvalid : host_rvalid, 1);
        check("other_rvalid", (who == 1'b0) ? host_rvalid : cpu_rvalid, 0);
    endtask

    initial begin
        int cpu_pos, host_pos, order, cyc;
        int cpu_early, host_early, same_early;
        int last_who;
        bit first_host_exp;

        for (int i = 0; i < 4096; i++) exp_mem[i] = 12'h000;
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        repeat (3) tick();
        check("rst_cpu_gnt", cpu_gnt, 0);
        check("rst_host_gnt", host_gnt, 0);
        check("rst_rvalid", {cpu_rvalid, host_rvalid}, 0);
        check("rst_mem_wren", mem_wren, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_rdata", {cpu_rdata, host_rdata}, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 1);
        reset = 1'b1;
        tick();

        access(1'b0, 1'b1, 12'h010, 12'hABC);
        access(1'b1, 1'b0, 12'h010, 12'h000);
        access(1'b1, 1'b1, 12'h000, 12'h111);
        access(1'b1, 1'b1, 12'hFFF, 12'h3C3);
        access(1'b0, 1'b0, 12'hFFF, 12'h000);
        access(1'b1, 1'b0, 12'h000, 12'h000);

        // Reset landing in the RDATA cycle of a CPU read
        access(1'b0, 1'b1, 12'h123, 12'h5A5);
        access(1'b0, 1'b1, 12'h124, 12'h0AA);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
        tick();
        check("rd_gnt", cpu_gnt, 1);
        cpu_req = 1'b0;
        tick();
        check("rd_in_rdata", busy, 1);
        reset = 1'b0;
        tick();
        check("rstrd_rvalid", cpu_rvalid, 0);
        check("rstrd_busy", busy, 0);
        check("rstrd_rdata", cpu_rdata, 0);
        check("rstrd_owner", owner, 1);
        check("rstrd_mem_address", mem_address, 0);
        reset = 1'b1;
        tick();

        // Reset landing in the GRANT cycle of a CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h124; cpu_wdata = 12'h777;
        tick();
        check("wr_gnt", cpu_gnt, 1);
        check("wr_wren", mem_wren, 1);
        cpu_req = 1'b0;
        reset = 1'b0;
        #1;
        check("rstwr_wren_forced", mem_wren, 0);
        tick();
        reset = 1'b1;
        check("rstwr_busy", busy, 0);
        tick();
        access(1'b1, 1'b0, 12'h124, 12'h000);
        access(1'b0, 1'b0, 12'h123, 12'h000);

        // Simultaneous reads with CPU as last owner
        check("tie_owner_pre", owner, 0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'hFFF;
        cpu_exp_q.push_back(exp_mem[12'h010]);
        host_exp_q.push_back(exp_mem[12'hFFF]);
        cpu_pos = 0; host_pos = 0; order = 0; cyc = 0;
        while (cyc < 30 && !(cpu_pos != 0 && host_pos != 0 && !busy)) begin
            tick();
            cyc++;
            if (cpu_gnt) begin order++; cpu_pos = order; cpu_req = 1'b0; end
            if (host_gnt) begin order++; host_pos = order; host_req = 1'b0; end
        end
        cpu_req = 1'b0; host_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        first_host_exp = 1'b1;
`else
        first_host_exp = 1'b0;
`endif
        check("tie_both_served", (cpu_pos != 0) && (host_pos != 0), 1);
        check("tie_host_first", host_pos < cpu_pos, first_host_exp);

        // Continuous CPU traffic against a waiting host
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h000;
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'h010;
        cpu_early = 0; host_early = 0; same_early = 0; last_who = -1; cyc = 0;
        while (cyc < 80 && (cpu_req || host_req || busy)) begin
            tick();
            cyc++;
            if (cpu_gnt) begin
                cpu_exp_q.push_back(exp_mem[12'h000]);
                if (cyc <= 20) begin
                    cpu_early++;
                    if (last_who == 0) same_early++;
                end
                last_who = 0;
                if (cyc > 20) cpu_req = 1'b0;
            end
            if (host_gnt) begin
                host_exp_q.push_back(exp_mem[12'h010]);
                if (cyc <= 20) begin
                    host_early++;
                    if (last_who == 1) same_early++;
                end
                last_who = 1;
                if (cyc > 20) host_req = 1'b0;
            end
        end
        check("stream_drained", cpu_req | host_req | busy, 0);
        check("stream_total_early", cpu_early + host_early, 7);
`ifdef ARB_ROUND_ROBIN_EN
        check("rr_alternate", same_early, 0);
        check("rr_host_served", host_early >= 3, 1);
`else
        check("fixed_host_starved", host_early, 0);
        check("fixed_cpu_grants", cpu_early, 7);
`endif
        repeat (3) tick();
        check("cpu_queue_empty", cpu_exp_q.size(), 0);
        check("host_queue_empty", host_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
